fetch_stage: RTL and testbench

- Instruction-fetch stage sitting directly downstream of the program counter register.
- Consumes the current PC and the instruction word read at that address, and produces the IF/ID pipeline register (instruction, PC+4, valid).
- Generates pc_write, the enable for the PC register.
- Owns the I/O wait: when an IN/OUT instruction is fetched, it freezes fetch until the operator toggles Enter. The toggle is synchronized and debounced.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/enter_debounce.sv | 55 +++++
 rtl/fetch_stage.sv | 98 +++++++++
 tb/tb_fetch_stage.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcodes, widths and fetch FSM encoding
package mips_pkg;

    localparam int PKG_ADDR_WIDTH = 5;
    localparam int DATA_WIDTH     = 2 ** PKG_ADDR_WIDTH;

    localparam logic [5:0] OP_IN  = 6'h1C;
    localparam logic [5:0] OP_OUT = 6'h1D;

    localparam logic [DATA_WIDTH-1:0] NOP_WORD = '0;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_WAIT_IO = 1'b1
    } fetch_state_e;

    // True for the two opcodes that freeze fetch until the operator responds
    function automatic logic is_io_op(input logic [5:0] op);
        return (op == OP_IN) || (op == OP_OUT);
    endfunction

endpackage

// File: rtl/enter_debounce.sv
// rtl/enter_debounce.sv - Enter synchronizer, reference capture and mismatch counter
module enter_debounce #(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enter_i,
    input  logic capture_i,
    input  logic hold_i,
    output logic release_o
);

    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE - 1);

    logic       sync1_q;
    logic       sync2_q;
    logic       ref_q;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       mismatch;

    // The counter only advances while waiting and the level differs from the one seen at entry
    assign mismatch = (sync2_q != ref_q);

    // Next count and release: any agreeing cycle restarts the count, so glitches never release
    always_comb begin
        cnt_d     = '0;
        release_o = 1'b0;
        if (hold_i && mismatch) begin
            if (cnt_q == DB_LAST) begin
                release_o = 1'b1;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    // Two-flop synchronizer runs continuously; reference latched when an IN/OUT is fetched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            ref_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= enter_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            if (capture_i) begin
                ref_q <= sync2_q;
            end
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with IF/ID register and IN/OUT operator wait
module fetch_stage
    import mips_pkg::*;
#(
    parameter int ADDR_WIDTH = PKG_ADDR_WIDTH,
    parameter int DEBOUNCE   = 4,
    localparam int W         = 2 ** ADDR_WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] pc_in,
    input  logic [W-1:0] imem_data,
    input  logic         stall,
    input  logic         flush,
    input  logic         Enter,
    output logic         pc_write,
    output logic [W-1:0] if_id_instr,
    output logic [W-1:0] if_id_pc4,
    output logic         if_id_valid,
    output logic         io_wait,
    output logic         is_input,
    output logic         is_output
);

    fetch_state_e state_q;
    logic [W-1:0] instr_q;
    logic [W-1:0] pc4_q;
    logic         valid_q;

    logic         capture;
    logic         hold;
    logic         release_pulse;
    logic [5:0]   fetch_op;
    logic [5:0]   latched_op;

    assign fetch_op   = imem_data[W-1 -: 6];
    assign latched_op = instr_q[W-1 -: 6];

    // A real load of an IN/OUT arms the wait; flush out of WAIT_IO must also clear the count
    assign capture = (state_q == ST_RUN) && !flush && !stall && is_io_op(fetch_op);
    assign hold    = (state_q == ST_WAIT_IO) && !flush;

    enter_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_enter_debounce (
        .clk       (clk),
        .rst_n     (reset),
        .enter_i   (Enter),
        .capture_i (capture),
        .hold_i    (hold),
        .release_o (release_pulse)
    );

    // Fetch FSM and IF/ID register: flush beats stall beats load; WAIT_IO ignores stall
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            instr_q <= W'(NOP_WORD);
            pc4_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (flush) begin
                        instr_q <= W'(NOP_WORD);
                        valid_q <= 1'b0;
                    end else if (!stall) begin
                        instr_q <= imem_data;
                        pc4_q   <= pc_in + W'(4);
                        valid_q <= 1'b1;
                        if (is_io_op(fetch_op)) begin
                            state_q <= ST_WAIT_IO;
                        end
                    end
                end
                ST_WAIT_IO: begin
                    if (flush) begin
                        instr_q <= W'(NOP_WORD);
                        valid_q <= 1'b0;
                        state_q <= ST_RUN;
                    end else if (release_pulse) begin
                        state_q <= ST_RUN;
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    assign pc_write    = (state_q == ST_RUN) && !stall && reset;
    assign io_wait     = (state_q == ST_WAIT_IO);
    assign if_id_instr = instr_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;
    assign is_input    = valid_q && (latched_op == OP_IN);
    assign is_output   = valid_q && (latched_op == OP_OUT);

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage against a pin-history reference model
module tb_fetch_stage;

    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pc_in = '0;
    logic [31:0] imem_data = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        Enter = 1'b0;
    logic        pc_write;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        io_wait;
    logic        is_input;
    logic        is_output;

    fetch_stage #(
        .ADDR_WIDTH (5),
        .DEBOUNCE   (DEB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .imem_data   (imem_data),
        .stall       (stall),
        .flush       (flush),
        .Enter       (Enter),
        .pc_write    (pc_write),
        .if_id_instr (if_id_instr),
        .if_id_pc4   (if_id_pc4),
        .if_id_valid (if_id_valid),
        .io_wait     (io_wait),
        .is_input    (is_input),
        .is_output   (is_output)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic        wait_io;
        logic        is_in;
        logic        is_out;
        logic        pc_write;
    } obs_t;

    obs_t sb[$];
    int   checks = 0;
    int   passed = 0;

    // Reference model: architectural IF/ID contents plus the history of the Enter pin per edge
    bit          hist[0:8191];
    int          n = 0;
    int          last_rst = 0;
    int          m_e0 = 0;
    bit          m_ref = 1'b0;
    logic [31:0] m_instr = '0;
    logic [31:0] m_pc4 = '0;
    bit          m_valid = 1'b0;
    bit          m_wait = 1'b0;

    function automatic bit pin_at(int k);
        if (k < 0 || k <= last_rst) return 1'b0;
        return hist[k];
    endfunction

    // Released at edge e when the Enter level seen by the last DEB edges of the wait all differ from ref
    function automatic bit released(int e);
        for (int j = 0; j < DEB; j++) begin
            if (e - j <= m_e0) return 1'b0;
            if (pin_at(e - j - 2) == m_ref) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic bit is_io(logic [31:0] w);
        return (w[31:26] == 6'h1C) || (w[31:26] == 6'h1D);
    endfunction

    task automatic model_reset();
        m_instr = '0;
        m_pc4   = '0;
        m_valid = 1'b0;
        m_wait  = 1'b0;
    endtask

    task automatic model_edge();
        hist[n] = Enter;
        if (!reset) begin
            last_rst = n;
            model_reset();
        end else if (!m_wait) begin
            if (flush) begin
                m_instr = '0;
                m_valid = 1'b0;
            end else if (!stall) begin
                m_instr = imem_data;
                m_pc4   = pc_in + 32'd4;
                m_valid = 1'b1;
                if (is_io(imem_data)) begin
                    m_wait = 1'b1;
                    m_e0   = n;
                    m_ref  = pin_at(n - 2);
                end
            end
        end else begin
            if (flush) begin
                m_instr = '0;
                m_valid = 1'b0;
                m_wait  = 1'b0;
            end else if (released(n)) begin
                m_wait = 1'b0;
            end
        end
        n++;
    endtask

    function automatic obs_t expect_now();
        obs_t e;
        e.instr    = m_instr;
        e.pc4      = m_pc4;
        e.valid    = m_valid;
        e.wait_io  = m_wait;
        e.is_in    = m_valid && (m_instr[31:26] == 6'h1C);
        e.is_out   = m_valid && (m_instr[31:26] == 6'h1D);
        e.pc_write = reset && !m_wait && !stall;
        return e;
    endfunction

    function automatic obs_t actual_now();
        return {if_id_instr, if_id_pc4, if_id_valid, io_wait, is_input, is_output, pc_write};
    endfunction

    task automatic check(string name, obs_t act, obs_t exp_v);
        checks++;
        if (act === exp_v) begin
            passed++;
        end else begin
            $display("FAIL %s at edge %0d: got %h expected %h", name, n, act, exp_v);
        end
    endtask

    // One cycle of stimulus: let the edge happen, advance the model, apply new inputs, queue expectation
    task automatic drive(bit rst, logic [31:0] pc, logic [31:0] d, bit st, bit fl, bit en);
        @(posedge clk);
        model_edge();
        #1;
        reset     = rst;
        pc_in     = pc;
        imem_data = d;
        stall     = st;
        flush     = fl;
        Enter     = en;
        if (!rst) begin
            last_rst = n - 1;
            model_reset();
        end
        sb.push_back(expect_now());
    endtask

    function automatic logic [31:0] rand_word();
        int r;
        r = $urandom_range(0, 5);
        if (r == 0) return {6'h1C, 26'($urandom)};
        if (r == 1) return {6'h1D, 26'($urandom)};
        return $urandom;
    endfunction

    // Monitor: compares the DUT outputs against the oldest queued expectation, away from the clock edge
    always @(negedge clk) begin
        obs_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("ifid", actual_now(), e);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] w_in;
        logic [31:0] w_out;
        bit          en;
        int          guard;
        w_in  = {6'h1C, 26'h0000005};
        w_out = {6'h1D, 26'h0000009};

        #3;
        check("reset", actual_now(), obs_t'(0));

        drive(0, 32'h0, 32'h0, 0, 0, 0);
        drive(0, 32'h0, 32'h0, 0, 0, 0);

        // Reset then run, including PC+4 wrap
        drive(1, 32'h0000_0000, 32'h2008_0005, 0, 0, 0);
        drive(1, 32'h0000_0004, 32'h0109_5020, 0, 0, 0);
        drive(1, 32'hFFFF_FFFC, 32'h8C0A_0000, 0, 0, 0);

        // Stall and flush together, then stall alone
        drive(1, 32'h0000_0008, 32'h0000_1234, 1, 1, 0);
        repeat (3) drive(1, 32'h0000_000C, 32'h0000_DEAD, 1, 0, 0);

        // IN wait with Enter low, then a clean rising toggle
        drive(1, 32'h0000_000C, w_in, 0, 0, 0);
        repeat (3) drive(1, 32'h0000_0010, 32'h0000_0001, 0, 0, 0);
        repeat (8) drive(1, 32'h0000_0010, 32'h0000_0001, 0, 0, 1);

        // IN with Enter high: short low glitch, then a sustained low level
        drive(1, 32'h0000_0010, w_in, 0, 0, 1);
        repeat (3) drive(1, 32'h0000_0014, 32'h0000_0002, 0, 0, 1);
        repeat (2) drive(1, 32'h0000_0014, 32'h0000_0002, 0, 0, 0);
        repeat (5) drive(1, 32'h0000_0014, 32'h0000_0002, 1, 0, 1);
        repeat (8) drive(1, 32'h0000_0014, 32'h0000_0002, 0, 0, 0);

        // OUT squashed by flush while waiting
        drive(1, 32'h0000_0014, w_out, 0, 0, 0);
        repeat (3) drive(1, 32'h0000_0018, 32'h0000_0003, 0, 0, 0);
        drive(1, 32'h0000_0018, 32'h0000_0003, 0, 1, 0);
        repeat (2) drive(1, 32'h0000_0040, 32'h0000_0004, 0, 0, 0);

        // Asynchronous reset in the middle of a wait, then normal fetch resumes
        drive(1, 32'h0000_0044, w_in, 0, 0, 0);
        repeat (2) drive(1, 32'h0000_0048, 32'h0000_0005, 0, 0, 1);
        drive(0, 32'h0000_0048, 32'h0000_0005, 0, 0, 1);
        #1;
        check("async_reset", actual_now(), obs_t'(0));
        drive(0, 32'h0000_0000, 32'h0000_0000, 0, 0, 0);
        drive(1, 32'h0000_0000, 32'h2008_0005, 0, 0, 0);
        repeat (2) drive(1, 32'h0000_0004, 32'h0000_0006, 0, 0, 0);

        // Randomized traffic with long Enter holds so waits release as well as get flushed
        en = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 6) == 0) en = ~en;
            drive(1, $urandom, rand_word(),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0), en);
        end

        guard = 0;
        while (sb.size() != 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        #1;
        checks++;
        if (sb.size() == 0) begin
            passed++;
        end else begin
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
